// File: rtl/alu_serial_n.sv
// Sequential ALU for WIDTH-bit operands. One CHUNK-bit slice is reused each clock,
// starting with the least significant chunk. A Start/Busy/Done handshake controls it.
// Result, CarryOut, Zero and Overflow are registered. They hold from one Done to the next.
module alu_serial_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Overflow
);

    localparam int unsigned NumChunks = WIDTH / CHUNK;
    localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

    if ((WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("alu_serial_n: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] f_chunk;
    logic [CHUNK:0]   c_chain;
    logic [WIDTH-1:0] res_shift;

    // One CHUNK-wide slice acts on the low bits of the operand shift registers.
    always_comb begin
        f_chunk    = '0;
        c_chain    = '0;
        c_chain[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            case (op_q)
                2'b00: begin
                    f_chunk[i]   = a_q[i] & ~b_q[i];
                    c_chain[i+1] = 1'b0;
                end
                2'b01: begin
                    f_chunk[i]   = ~a_q[i];
                    c_chain[i+1] = 1'b0;
                end
                default: begin
                    // For increment, b_q was cleared and carry_q was preset to 1 at accept.
                    f_chunk[i]   = a_q[i] ^ b_q[i] ^ c_chain[i];
                    c_chain[i+1] = (a_q[i] & b_q[i]) | (c_chain[i] & (a_q[i] ^ b_q[i]));
                end
            endcase
        end
        res_shift = (res_q >> CHUNK) | (WIDTH'(f_chunk) << (WIDTH - CHUNK));
    end

    // Sequencing: accept an op, run it chunk by chunk, then publish the result and flags.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (Start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    op_d    = S;
                    a_d     = A;
                    b_d     = (S == 2'b10) ? '0 : B;
                    carry_d = (S == 2'b10) | ((S == 2'b11) & CarryIn);
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                busy_d  = 1'b1;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = c_chain[CHUNK];
                res_d   = res_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = res_shift;
                    zero_d   = ~|res_shift;
                    cout_d   = op_q[1] & c_chain[CHUNK];
                    // Signed overflow: the carry into the MSB differs from the carry out of it.
                    ovf_d    = op_q[1] & (c_chain[CHUNK] ^ c_chain[CHUNK-1]);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset aborts any op in flight.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Result   = result_q;
    assign CarryOut = cout_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_n.sv
// Testbench for alu_serial_n. It uses four instances: (8,1), (8,4), (16,2) and (16,16).
// Directed scenarios run first, then a randomized regression against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_serial_n;

    localparam int W [4] = '{8, 8, 16, 16};
    localparam int C [4] = '{1, 4, 2, 16};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  s;
    logic        cin;
    logic [3:0]  start;
    logic [7:0]  a0, b0, a1, b1;
    logic [15:0] a2, b2, a3, b3;
    logic [3:0]  busy, done, cout, zero, ovf;
    logic [7:0]  res0, res1;
    logic [15:0] res2, res3;

    int checks = 0;
    int failures = 0;
    int dn [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    alu_serial_n #(.WIDTH(8), .CHUNK(1)) u0 (
        .Clock(clk), .Reset_n(rst_n), .Start(start[0]), .S(s), .A(a0), .B(b0), .CarryIn(cin),
        .Busy(busy[0]), .Done(done[0]), .Result(res0), .CarryOut(cout[0]), .Zero(zero[0]),
        .Overflow(ovf[0]));
    alu_serial_n #(.WIDTH(8), .CHUNK(4)) u1 (
        .Clock(clk), .Reset_n(rst_n), .Start(start[1]), .S(s), .A(a1), .B(b1), .CarryIn(cin),
        .Busy(busy[1]), .Done(done[1]), .Result(res1), .CarryOut(cout[1]), .Zero(zero[1]),
        .Overflow(ovf[1]));
    alu_serial_n #(.WIDTH(16), .CHUNK(2)) u2 (
        .Clock(clk), .Reset_n(rst_n), .Start(start[2]), .S(s), .A(a2), .B(b2), .CarryIn(cin),
        .Busy(busy[2]), .Done(done[2]), .Result(res2), .CarryOut(cout[2]), .Zero(zero[2]),
        .Overflow(ovf[2]));
    alu_serial_n #(.WIDTH(16), .CHUNK(16)) u3 (
        .Clock(clk), .Reset_n(rst_n), .Start(start[3]), .S(s), .A(a3), .B(b3), .CarryIn(cin),
        .Busy(busy[3]), .Done(done[3]), .Result(res3), .CarryOut(cout[3]), .Zero(zero[3]),
        .Overflow(ovf[3]));

    // Count Done pulses per instance.
    always @(posedge clk) begin
        if (done[0]) dn[0] <= dn[0] + 1;
        if (done[1]) dn[1] <= dn[1] + 1;
        if (done[2]) dn[2] <= dn[2] + 1;
        if (done[3]) dn[3] <= dn[3] + 1;
    end

    // Returns {busy, done, ovf, zero, cout, result[15:0]}.
    function automatic logic [20:0] outs(input bit [1:0] k);
        case (k)
            2'd0: return {busy[0], done[0], ovf[0], zero[0], cout[0], 8'h00, res0};
            2'd1: return {busy[1], done[1], ovf[1], zero[1], cout[1], 8'h00, res1};
            2'd2: return {busy[2], done[2], ovf[2], zero[2], cout[2], res2};
            default: return {busy[3], done[3], ovf[3], zero[3], cout[3], res3};
        endcase
    endfunction

    task automatic set_ops(input bit [1:0] k, input logic [15:0] a, input logic [15:0] b);
        case (k)
            2'd0: begin a0 = a[7:0]; b0 = b[7:0]; end
            2'd1: begin a1 = a[7:0]; b1 = b[7:0]; end
            2'd2: begin a2 = a; b2 = b; end
            default: begin a3 = a; b3 = b; end
        endcase
    endtask

    // Reference model: {ovf, zero, cout, result} computed using integer arithmetic.
    function automatic logic [18:0] ref_op(input int w, input logic [1:0] op,
                                           input logic [15:0] a, input logic [15:0] b,
                                           input logic c);
        longint mask, half, ua, ub, cc, sum, sa, sb, ss, r;
        logic co, v;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        cc = 0;
        co = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: r = ua & ~ub & mask;
            2'b01: r = ~ua & mask;
            default: begin
                if (op == 2'b10) begin
                    ub = 0;
                    cc = 1;
                end else begin
                    cc = c ? 1 : 0;
                end
                sum = ua + ub + cc;
                r = sum & mask;
                co = ((sum >> w) & 1) != 0;
                sa = (ua >= half) ? ua - (mask + 1) : ua;
                sb = (ub >= half) ? ub - (mask + 1) : ub;
                ss = sa + sb + cc;
                v = (ss >= half) || (ss < -half);
            end
        endcase
        return {v, (r == 0), co, 16'(r)};
    endfunction

    // Issue one op to instance k and wait (bounded) for Done. lat is the Done cycle after
    // the Start edge, or 0 if Done did not arrive. With b2b set, Start is raised in the
    // current cycle (the previous Done cycle).
    task automatic go(input bit [1:0] k, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic c, input bit b2b,
                      output int lat, output int busy_n);
        logic [20:0] o;
        if (!b2b) @(negedge clk);
        s = op;
        set_ops(k, a, b);
        cin = c;
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        lat = 0;
        busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            o = outs(k);
            if (o[20]) busy_n++;
            if (o[19]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = '0;
        s = 2'b00;
        cin = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
        #22;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs(2'(i)) !== 21'h0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=0", i, outs(2'(i)));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_wrap;
        int lat, bn;
        go(2'd0, 2'b11, 16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bn);
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL add_wrap_latency got=%0d exp=9", lat); end
        checks++;
        if (bn !== 8) begin failures++; $display("FAIL add_wrap_busy_cycles got=%0d exp=8", bn); end
        checks++;
        if (outs(2'd0) !== {2'b01, 1'b0, 1'b1, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL add_wrap_result got=%h exp=%h", outs(2'd0), {2'b01, 3'b011, 16'h0});
        end
        @(negedge clk);
        checks++;
        if (outs(2'd0) !== {2'b00, 1'b0, 1'b1, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL done_one_cycle_hold got=%h exp=%h", outs(2'd0), {5'b00011, 16'h0});
        end
    endtask

    task automatic test_inc_ignores_carry;
        int lat, bn;
        for (int c = 0; c < 2; c++) begin
            go(2'd0, 2'b10, 16'h007F, 16'h005A, c[0], 1'b0, lat, bn);
            checks++;
            if (lat !== 9 || outs(2'd0)[18:0] !== {1'b1, 1'b0, 1'b0, 16'h0080}) begin
                failures++;
                $display("FAIL inc_cin%0d got=%h lat=%0d exp=%h lat=9", c, outs(2'd0)[18:0],
                         lat, {3'b100, 16'h0080});
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        go(2'd0, 2'b00, 16'h00F0, 16'h003C, 1'b0, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || outs(2'd0)[18:0] !== {3'b000, 16'h00C0}) begin
            failures++;
            $display("FAIL andnot got=%h lat=%0d exp=%h lat=9", outs(2'd0)[18:0], lat,
                     {3'b000, 16'h00C0});
        end
        go(2'd0, 2'b01, 16'h00A5, 16'h0000, 1'b0, 1'b1, lat, bn);
        checks++;
        if (lat !== 9 || bn !== 8 || outs(2'd0)[18:0] !== {3'b000, 16'h005A}) begin
            failures++;
            $display("FAIL b2b_not got=%h lat=%0d busy=%0d exp=%h lat=9 busy=8",
                     outs(2'd0)[18:0], lat, bn, {3'b000, 16'h005A});
        end
    endtask

    task automatic test_ignore_during_run;
        int lat;
        int extra;
        @(negedge clk);
        s = 2'b11; a0 = 8'h55; b0 = 8'h22; cin = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start[0] = 1'b1; s = 2'b01; a0 = 8'h00; b0 = 8'hFF; cin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        lat = 0;
        for (int i = 5; i <= 20; i++) begin
            @(negedge clk);
            if (done[0]) begin lat = i; break; end
        end
        checks++;
        if (lat !== 9 || outs(2'd0)[18:0] !== {3'b000, 16'h0077}) begin
            failures++;
            $display("FAIL ignore_in_run got=%h lat=%0d exp=%h lat=9", outs(2'd0)[18:0], lat,
                     {3'b000, 16'h0077});
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done[0] || busy[0]) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL ignored_start_started_op got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bn, late;
        @(negedge clk);
        s = 2'b11; a0 = 8'h0F; b0 = 8'h01; cin = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs(2'd0) !== 21'h0) begin
            failures++;
            $display("FAIL reset_mid_run got=%h exp=0", outs(2'd0));
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done[0]) late++;
        end
        checks++;
        if (late !== 0) begin failures++; $display("FAIL done_after_abort got=%0d exp=0", late); end
        go(2'd0, 2'b11, 16'h0012, 16'h0034, 1'b1, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || outs(2'd0)[18:0] !== {3'b000, 16'h0047}) begin
            failures++;
            $display("FAIL add_after_reset got=%h lat=%0d exp=%h lat=9", outs(2'd0)[18:0], lat,
                     {3'b000, 16'h0047});
        end
    endtask

    task automatic test_chunk4;
        int lat, bn;
        go(2'd1, 2'b11, 16'h0080, 16'h0080, 1'b0, 1'b0, lat, bn);
        checks++;
        if (lat !== 3 || bn !== 2) begin
            failures++;
            $display("FAIL chunk4_timing got lat=%0d busy=%0d exp lat=3 busy=2", lat, bn);
        end
        checks++;
        if (outs(2'd1)[18:0] !== {3'b111, 16'h0000}) begin
            failures++;
            $display("FAIL chunk4_result got=%h exp=%h", outs(2'd1)[18:0], {3'b111, 16'h0});
        end
    endtask

    task automatic test_random;
        int base [4];
        int lat [4];
        logic [15:0] ra [4];
        logic [15:0] rb [4];
        logic [1:0] op;
        logic c;
        logic [18:0] exp_v;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) base[k] = dn[k];
        for (int n = 0; n < 1000; n++) begin
            op = 2'($urandom_range(0, 3));
            c = 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 2; j++) begin
                    logic [15:0] v;
                    case ($urandom_range(0, 7))
                        0: v = 16'h0000;
                        1: v = 16'hFFFF;
                        2: v = 16'h8000 >> (16 - W[k]);
                        default: v = 16'($urandom);
                    endcase
                    if (W[k] == 8) v = v & 16'h00FF;
                    if (j == 0) ra[k] = v; else rb[k] = v;
                end
            end
            @(negedge clk);
            s = op;
            cin = c;
            for (int k = 0; k < 4; k++) set_ops(2'(k), ra[k], rb[k]);
            start = 4'hF;
            @(posedge clk);
            #1;
            start = 4'h0;
            for (int k = 0; k < 4; k++) lat[k] = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) if (done[k] && lat[k] == 0) lat[k] = i;
                if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
            end
            for (int k = 0; k < 4; k++) begin
                exp_v = ref_op(W[k], op, ra[k], rb[k], c);
                checks++;
                if (lat[k] !== W[k] / C[k] + 1 || outs(2'(k))[18:0] !== exp_v) begin
                    failures++;
                    $display("FAIL random op=%0d inst=%0d a=%h b=%h c=%0d got=%h lat=%0d exp=%h",
                             op, k, ra[k], rb[k], c, outs(2'(k))[18:0], lat[k], exp_v);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dn[k] - base[k] !== 1000) begin
                failures++;
                $display("FAIL done_count inst=%0d got=%0d exp=1000", k, dn[k] - base[k]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_inc_ignores_carry();
        test_back_to_back();
        test_ignore_during_run();
        test_reset_mid_run();
        test_chunk4();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
